ascon_permutation_core: RTL and testbench

//  Ascon p^a permutation engine that sits directly downstream of the AXI4-Lite register slave.
//  - The slave writes the 320-bit state one 32-bit word at a time, issues start, and reads the result back.
//  - Iterative: ROUNDS_PER_CYCLE rounds per clock; supports a = 6, 8 or 12.

---
 rtl/ascon_permutation_core_pkg.sv | 42 ++++
 rtl/ascon_permutation_core_if.sv | 33 +++
 rtl/ascon_permutation_core_round.sv | 48 ++++
 rtl/ascon_permutation_core.sv | 110 +++++++++++
 tb/tb_ascon_permutation_core.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/ascon_permutation_core_pkg.sv
// Shared types for the Ascon permutation core: state struct, FSM states, rotations, round constant.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package ascon_pkg;

  localparam int ASCON_WORDS = 10;

  // x0 sits in the MSBs so that 32-bit word k maps to x[k/2], even k = high half
  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } ascon_state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_t;

  localparam int ROT_X0_A = 19;
  localparam int ROT_X0_B = 28;
  localparam int ROT_X1_A = 61;
  localparam int ROT_X1_B = 39;
  localparam int ROT_X2_A = 1;
  localparam int ROT_X2_B = 6;
  localparam int ROT_X3_A = 10;
  localparam int ROT_X3_B = 17;
  localparam int ROT_X4_A = 7;
  localparam int ROT_X4_B = 41;

  function automatic logic [7:0] rc(input logic [3:0] r);
    return {~r, r};
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_permutation_core_if.sv
// Load/start/readback bus between the register slave (master) and the permutation core (slave).
// Latency: wires only; err is present only when ASCON_PERM_PROTECT_EN is defined.
// Backpressure: none; the master polls busy/done before reading results.
interface ascon_permutation_core_if;
  logic        ld_valid;
  logic [3:0]  ld_idx;
  logic [31:0] ld_data;
  logic        start;
  logic [3:0]  rounds;
  logic [3:0]  rd_idx;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;
`ifdef ASCON_PERM_PROTECT_EN
  logic        err;
`endif

  modport master (
    output ld_valid, ld_idx, ld_data, start, rounds, rd_idx,
    input  rd_data, busy, done
`ifdef ASCON_PERM_PROTECT_EN
    , input err
`endif
  );

  modport slave (
    input  ld_valid, ld_idx, ld_data, start, rounds, rd_idx,
    output rd_data, busy, done
`ifdef ASCON_PERM_PROTECT_EN
    , output err
`endif
  );
endinterface

// File: rtl/ascon_permutation_core_round.sv
// One Ascon round: constant addition, bitsliced 5-bit S-box, linear diffusion layer.
// Latency: purely combinational.
// Backpressure: n/a.
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_state_t s_in,
  input  logic [3:0]   r,
  output ascon_state_t s_out
);

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  // constant add, S-box (chi-like core wrapped in the Ascon pre/post XORs), then linear layer
  always_comb begin
    x0 = s_in.x0;
    x1 = s_in.x1;
    x2 = s_in.x2 ^ {56'h0, rc(r)};
    x3 = s_in.x3;
    x4 = s_in.x4;

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    s_out.x0 = x0 ^ ror64(x0, ROT_X0_A) ^ ror64(x0, ROT_X0_B);
    s_out.x1 = x1 ^ ror64(x1, ROT_X1_A) ^ ror64(x1, ROT_X1_B);
    s_out.x2 = x2 ^ ror64(x2, ROT_X2_A) ^ ror64(x2, ROT_X2_B);
    s_out.x3 = x3 ^ ror64(x3, ROT_X3_A) ^ ror64(x3, ROT_X3_B);
    s_out.x4 = x4 ^ ror64(x4, ROT_X4_A) ^ ror64(x4, ROT_X4_B);
  end

endmodule

// File: rtl/ascon_permutation_core.sv
// Iterative Ascon p^a engine (a = 6/8/12, ROUNDS_PER_CYCLE rounds per clock); optional err via ASCON_PERM_PROTECT_EN.
// Latency: start at edge T, last round group at edge T + a/ROUNDS_PER_CYCLE, done pulses the cycle after.
// Backpressure: none; loads/starts during RUN (and starts during DONE) are dropped.
module ascon_permutation_core
  import ascon_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  ascon_permutation_core_if.slave bus
);

  logic [0:ASCON_WORDS-1][31:0] st_w;
  fsm_t                         fsm;
  logic [3:0]                   r_cnt;
  logic                         busy_q;
  logic                         done_q;
  logic                         ld_ok;
  logic                         start_ok;
  logic                         last_grp;
  logic [3:0]                   i0;
  ascon_state_t                 chain [ROUNDS_PER_CYCLE+1];

  assign chain[0] = ascon_state_t'(st_w);

  for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
    ascon_round u_round (
      .s_in  (chain[g]),
      .r     (r_cnt + 4'(g)),
      .s_out (chain[g+1])
    );
  end

  assign ld_ok    = bus.ld_valid && (fsm != ST_RUN) && (bus.ld_idx < 4'(ASCON_WORDS));
  assign start_ok = bus.start && (fsm == ST_IDLE);
  assign last_grp = (r_cnt + 4'(ROUNDS_PER_CYCLE)) == 4'd12;

  // first round index from the requested count; anything unsupported runs the full 12
  always_comb begin
    i0 = 4'd0;
    case (bus.rounds)
      4'd6:    i0 = 4'd6;
      4'd8:    i0 = 4'd4;
      default: i0 = 4'd0;
    endcase
  end

  // state register, round counter and IDLE/RUN/DONE sequencing with registered busy/done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_w   <= '0;
      fsm    <= ST_IDLE;
      r_cnt  <= 4'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (ld_ok) st_w[bus.ld_idx] <= bus.ld_data;
      case (fsm)
        ST_IDLE: begin
          if (start_ok) begin
            fsm    <= ST_RUN;
            r_cnt  <= i0;
            busy_q <= 1'b1;
          end
        end
        ST_RUN: begin
          st_w  <= chain[ROUNDS_PER_CYCLE];
          r_cnt <= r_cnt + 4'(ROUNDS_PER_CYCLE);
          if (last_grp) begin
            fsm    <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          fsm    <= ST_IDLE;
          done_q <= 1'b0;
        end
        default: begin
          fsm    <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_data = (bus.rd_idx < 4'(ASCON_WORDS)) ? st_w[bus.rd_idx] : 32'h0;

`ifdef ASCON_PERM_PROTECT_EN
  logic err_q;
  logic err_cond;

  assign err_cond = (bus.ld_valid && ((fsm == ST_RUN) || (bus.ld_idx >= 4'(ASCON_WORDS))))
                  || (bus.start && (fsm == ST_RUN));

  // sticky error; only a clean accepted start wipes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         err_q <= 1'b0;
    else if (err_cond) err_q <= 1'b1;
    else if (start_ok) err_q <= 1'b0;
  end

  assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_ascon_permutation_core.sv
// Randomized bench for ascon_permutation_core against a table-driven Ascon model.
// Latency: checks busy length a/ROUNDS_PER_CYCLE and a single-cycle done pulse.
// Backpressure: exercises dropped loads/starts during RUN and mid-run reset.
module tb_ascon_permutation_core;

  localparam int RPC = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ascon_permutation_core_if bus ();

  ascon_permutation_core #(.ROUNDS_PER_CYCLE(RPC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  bit [31:0] mw [10];
  bit [4:0]  sbox [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                           5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                           5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                           5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  int rot_a [5] = '{19, 61, 1, 10, 7};
  int rot_b [5] = '{28, 39, 6, 17, 41};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit [63:0] ror(input bit [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // reference: per-column S-box lookup over the 5x64 bit matrix, rounds 12-a .. 11
  function automatic void model_perm(input int a);
    bit [63:0] x [5];
    bit [4:0]  v;
    for (int i = 0; i < 5; i++) x[i] = {mw[2*i], mw[2*i+1]};
    for (int r = 12 - a; r < 12; r++) begin
      x[2] ^= 64'((15 - r) * 16 + r);
      for (int c = 0; c < 64; c++) begin
        v = sbox[{x[0][c], x[1][c], x[2][c], x[3][c], x[4][c]}];
        x[0][c] = v[4]; x[1][c] = v[3]; x[2][c] = v[2]; x[3][c] = v[1]; x[4][c] = v[0];
      end
      for (int i = 0; i < 5; i++) x[i] = x[i] ^ ror(x[i], rot_a[i]) ^ ror(x[i], rot_b[i]);
    end
    for (int i = 0; i < 5; i++) begin
      mw[2*i]   = x[i][63:32];
      mw[2*i+1] = x[i][31:0];
    end
  endfunction

  task automatic check_words(input string tag);
    for (int k = 0; k < 10; k++) begin
      bus.rd_idx = 4'(k);
      #1;
      chk($sformatf("%s_w%0d", tag, k), 64'(bus.rd_data), 64'(mw[k]));
    end
  endtask

  task automatic load_word(input logic [3:0] k, input logic [31:0] d);
    @(negedge clk);
    bus.ld_valid = 1'b1;
    bus.ld_idx   = k;
    bus.ld_data  = d;
    if (k < 4'd10) mw[k] = d;
    @(negedge clk);
    bus.ld_valid = 1'b0;
  endtask

  task automatic load_random();
    for (int k = 0; k < 10; k++) load_word(4'(k), $urandom);
  endtask

  task automatic run_perm(input string tag, input logic [3:0] a_in, input bit inj,
                          input bit ld_en, input logic [3:0] ld_k, input logic [31:0] ld_d);
    int exp_a;
    int busy_n;
    bit seen;
    exp_a = (a_in == 4'd6 || a_in == 4'd8) ? int'(a_in) : 12;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.rounds = a_in;
    if (ld_en) begin
      bus.ld_valid = 1'b1;
      bus.ld_idx   = ld_k;
      bus.ld_data  = ld_d;
      if (ld_k < 4'd10) mw[ld_k] = ld_d;
    end
    @(negedge clk);
    bus.start    = 1'b0;
    bus.ld_valid = 1'b0;
    busy_n = 0;
    seen   = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (bus.done) seen = 1'b1;
      else begin
        if (bus.busy) busy_n++;
        if (inj && c == 2) begin
          bus.ld_valid = 1'b1;
          bus.ld_idx   = 4'd0;
          bus.ld_data  = 32'hFFFF_FFFF;
          bus.start    = 1'b1;
          bus.rounds   = 4'd6;
        end else begin
          bus.ld_valid = 1'b0;
          bus.start    = 1'b0;
        end
        @(negedge clk);
      end
    end
    bus.ld_valid = 1'b0;
    bus.start    = 1'b0;
    model_perm(exp_a);
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_busy_len"}, 64'(busy_n), 64'(exp_a / RPC));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    check_words(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit seen;
    bus.ld_valid = 1'b0;
    bus.ld_idx   = 4'd0;
    bus.ld_data  = 32'h0;
    bus.start    = 1'b0;
    bus.rounds   = 4'd12;
    bus.rd_idx   = 4'd0;
    for (int k = 0; k < 10; k++) mw[k] = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // reset state
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
`ifdef ASCON_PERM_PROTECT_EN
    chk("rst_err", 64'(bus.err), 64'd0);
`endif
    check_words("rst");

    // reset asserted mid-run aborts without done and clears state
    load_random();
    @(negedge clk);
    bus.start  = 1'b1;
    bus.rounds = 4'd12;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_busy_before", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk("midrst_no_done", 64'(seen), 64'd0);
    for (int k = 0; k < 10; k++) mw[k] = 32'h0;
    check_words("midrst");

    // load / readback, out-of-range index ignored
    for (int k = 0; k < 10; k++) load_word(4'(k), 32'hA5A5_0000 + 32'(k));
    check_words("ldrb");
    load_word(4'd12, 32'hDEAD_BEEF);
    check_words("ld_oob");
    bus.rd_idx = 4'd12;
    #1;
    chk("rd_oob", 64'(bus.rd_data), 64'd0);
`ifdef ASCON_PERM_PROTECT_EN
    chk("err_oob", 64'(bus.err), 64'd1);
`endif

    // known-answer start vector
    for (int k = 0; k < 10; k++) load_word(4'(k), 32'h0);
    load_word(4'd0, 32'h8040_0C06);
    run_perm("kat", 4'd12, 1'b0, 1'b0, 4'd0, 32'h0);
`ifdef ASCON_PERM_PROTECT_EN
    chk("err_kat_clear", 64'(bus.err), 64'd0);
`endif

    // round counts including an unsupported value
    load_random(); run_perm("a6",  4'd6,  1'b0, 1'b0, 4'd0, 32'h0);
    load_random(); run_perm("a8",  4'd8,  1'b0, 1'b0, 4'd0, 32'h0);
    load_random(); run_perm("a12", 4'd12, 1'b0, 1'b0, 4'd0, 32'h0);
    load_random(); run_perm("a3",  4'd3,  1'b0, 1'b0, 4'd0, 32'h0);

    // load and start while running are dropped
    load_random(); run_perm("prot", 4'd12, 1'b1, 1'b0, 4'd0, 32'h0);
`ifdef ASCON_PERM_PROTECT_EN
    chk("err_prot", 64'(bus.err), 64'd1);
`endif
    load_random(); run_perm("clean", 4'd8, 1'b0, 1'b0, 4'd0, 32'h0);
`ifdef ASCON_PERM_PROTECT_EN
    chk("err_clean", 64'(bus.err), 64'd0);
`endif

    // load and start in the same IDLE cycle
    load_random(); run_perm("same", 4'd6, 1'b0, 1'b1, 4'd9, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
